// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register countdown scoreboard that produces the ID-stage
//               stall for RAW (normal and ID-resolved branch consumers), WAW
//               between writers of unequal latency, and the structural hazard
//               on a single non-pipelined MULDIV unit. Also keeps a saturating
//               count of stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int BR_EXTRA = 1,
    parameter int CW       = $clog2(MD_LAT + BR_EXTRA + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          id_branch,
    input  logic          id_reg_write,
    input  logic [AW-1:0] id_rw,
    input  logic [1:0]    id_class,
    input  logic          flush,
    output logic          stall,
    output logic [3:0]    stall_cause,
    output logic          md_busy,
    output logic [31:0]   stall_cycles
);

    // Instruction class encodings; the reserved code behaves like ALU.
    localparam logic [1:0] CLS_ALU    = 2'd0;
    localparam logic [1:0] CLS_LOAD   = 2'd1;
    localparam logic [1:0] CLS_MULDIV = 2'd2;

    // Issue values: class latency plus the branch head-room, so that a
    // normal consumer may go once the counter falls to BR_EXTRA and an
    // ID-resolved branch once it reaches zero.
    localparam logic [CW-1:0] NEW_ALU  = CW'(BR_EXTRA);
    localparam logic [CW-1:0] NEW_LOAD = CW'(LOAD_LAT + BR_EXTRA);
    localparam logic [CW-1:0] NEW_MD   = CW'(MD_LAT - 1 + BR_EXTRA);
    localparam logic [CW-1:0] MD_OCC   = CW'(MD_LAT);
    localparam logic [CW-1:0] BR_X     = CW'(BR_EXTRA);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = '0;
    localparam logic [AW-1:0] R_ZERO   = '0;
    localparam logic [31:0]   SAT_MAX  = 32'hFFFF_FFFF;

    // Scoreboard state. Entry 0 is reset and never loaded, so it reads 0.
    logic [CW-1:0] r_cnt [NREG];
    logic [CW-1:0] r_md_cnt;
    logic [31:0]   r_stall_cycles;

    logic [CW-1:0] w_newcnt;
    logic [CW-1:0] w_cnt_rs;
    logic [CW-1:0] w_cnt_rt;
    logic [CW-1:0] w_cnt_rw;
    logic          w_rs_live;
    logic          w_rt_live;
    logic          w_raw;
    logic          w_br_raw;
    logic          w_waw;
    logic          w_md_struct;
    logic          w_stall;
    logic          w_issue;
    logic          w_wr_en;
    logic          w_is_md;

    // Issue value for the instruction currently in ID, selected by class.
    always_comb begin
        w_newcnt = NEW_ALU;
        case (id_class)
            CLS_ALU:    w_newcnt = NEW_ALU;
            CLS_LOAD:   w_newcnt = NEW_LOAD;
            CLS_MULDIV: w_newcnt = NEW_MD;
            default:    w_newcnt = NEW_ALU;
        endcase
    end

    // Hazard detection against the pre-issue scoreboard contents; a
    // self-dependent instruction therefore sees only the older writer.
    always_comb begin
        w_cnt_rs    = r_cnt[id_rs];
        w_cnt_rt    = r_cnt[id_rt];
        w_cnt_rw    = r_cnt[id_rw];
        w_is_md     = (id_class == CLS_MULDIV);
        w_rs_live   = id_uses_rs && (id_rs != R_ZERO);
        w_rt_live   = id_uses_rt && (id_rt != R_ZERO);
        w_raw       = (w_rs_live && (w_cnt_rs > BR_X)) ||
                      (w_rt_live && (w_cnt_rt > BR_X));
        w_br_raw    = id_branch &&
                      ((w_rs_live && (w_cnt_rs != ZERO)) ||
                       (w_rt_live && (w_cnt_rt != ZERO)));
        w_waw       = id_reg_write && (id_rw != R_ZERO) && (w_cnt_rw > w_newcnt);
        w_md_struct = w_is_md && (r_md_cnt > ONE);
        w_stall     = id_valid && !flush &&
                      (w_raw || w_br_raw || w_waw || w_md_struct);
        w_issue     = id_valid && !flush && !w_stall;
        w_wr_en     = w_issue && id_reg_write && (id_rw != R_ZERO);
    end

    // Per-register countdown: a new writer overrides the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= ZERO;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_wr_en && (id_rw == AW'(r))) begin
                    r_cnt[r] <= w_newcnt;
                end else if (r_cnt[r] != ZERO) begin
                    r_cnt[r] <= r_cnt[r] - ONE;
                end
            end
        end
    end

    // MULDIV occupancy: loaded on issue of a MULDIV, then counts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_cnt <= ZERO;
        end else if (w_issue && w_is_md) begin
            r_md_cnt <= MD_OCC;
        end else if (r_md_cnt != ZERO) begin
            r_md_cnt <= r_md_cnt - ONE;
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != SAT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall        = w_stall;
    assign stall_cause  = w_stall ? {w_md_struct, w_waw, w_br_raw, w_raw} : 4'b0000;
    assign md_busy      = (r_md_cnt != ZERO);
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed-vector bench for hazard_scoreboard. The stimulus
//               process pushes hand-computed expectations into a queue and a
//               separate monitor pops and compares once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam logic [1:0] ALU = 2'd0;
    localparam logic [1:0] LD  = 2'd1;
    localparam logic [1:0] MD  = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_branch;
    logic          id_reg_write;
    logic [AW-1:0] id_rw;
    logic [1:0]    id_class;
    logic          flush;
    logic          stall;
    logic [3:0]    stall_cause;
    logic          md_busy;
    logic [31:0]   stall_cycles;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .id_reg_write (id_reg_write),
        .id_rw        (id_rw),
        .id_class     (id_class),
        .flush        (flush),
        .stall        (stall),
        .stall_cause  (stall_cause),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] id;
        logic        stall;
        logic [3:0]  cause;
        logic        busy;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sc    = 32'd0;
    logic [15:0] vec   = 16'd0;

    task automatic chk(input string what, input logic [15:0] id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %h expected %h", what, id, act, exp);
        end
    endtask

    // One ID-stage cycle: drive inputs after the edge and queue the expected
    // outputs. sc models the saturating stall counter as seen at this cycle.
    task automatic cyc(input logic r, input logic v, input logic [1:0] cls,
                       input logic wen, input logic [AW-1:0] rw,
                       input logic urs, input logic [AW-1:0] rs,
                       input logic urt, input logic [AW-1:0] rt,
                       input logic br, input logic fl,
                       input logic es, input logic [3:0] ec, input logic eb);
        exp_t x;
        @(posedge clk);
        #1;
        rst          = r;
        id_valid     = v;
        id_class     = cls;
        id_reg_write = wen;
        id_rw        = rw;
        id_uses_rs   = urs;
        id_rs        = rs;
        id_uses_rt   = urt;
        id_rt        = rt;
        id_branch    = br;
        flush        = fl;
        x.id    = vec;
        x.stall = es;
        x.cause = ec;
        x.busy  = eb;
        x.cyc   = sc;
        q.push_back(x);
        if (r) sc = 32'd0;
        else if (es && sc != 32'hFFFF_FFFF) sc = sc + 32'd1;
        vec = vec + 16'd1;
    endtask

    task automatic idle(input logic eb);
        cyc(1'b0, 1'b0, ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
            1'b0, 4'b0000, eb);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",        e.id, {31'd0, stall},   {31'd0, e.stall});
                chk("stall_cause",  e.id, {28'd0, stall_cause}, {28'd0, e.cause});
                chk("md_busy",      e.id, {31'd0, md_busy}, {31'd0, e.busy});
                chk("stall_cycles", e.id, stall_cycles,     e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd5;
        id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0; id_reg_write = 1'b0;
        id_rw = 5'd0; id_class = ALU; flush = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with a live reader of r5
        cyc(1,1,ALU,0,5'd0, 1,5'd5, 0,5'd0, 0,0, 0,4'b0000,0);
        cyc(1,1,ALU,0,5'd0, 1,5'd5, 0,5'd0, 0,0, 0,4'b0000,0);

        // LOAD r3 then dependent ALU: one raw stall
        cyc(0,1,LD ,1,5'd3,  0,5'd0, 0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,ALU,1,5'd10, 1,5'd3, 0,5'd0, 0,0, 1,4'b0001,0);
        cyc(0,1,ALU,1,5'd10, 1,5'd3, 0,5'd0, 0,0, 0,4'b0000,0);
        idle(0);

        // LOAD r4 then branch on r4: two stalls
        cyc(0,1,LD ,1,5'd4, 0,5'd0, 0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,ALU,0,5'd0, 1,5'd4, 0,5'd0, 1,0, 1,4'b0011,0);
        cyc(0,1,ALU,0,5'd0, 1,5'd4, 0,5'd0, 1,0, 1,4'b0010,0);
        cyc(0,1,ALU,0,5'd0, 1,5'd4, 0,5'd0, 1,0, 0,4'b0000,0);
        // ALU r4 then branch reading r4 through rt: one stall
        cyc(0,1,ALU,1,5'd4, 0,5'd0, 0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,ALU,0,5'd0, 0,5'd0, 1,5'd4, 1,0, 1,4'b0010,0);
        cyc(0,1,ALU,0,5'd0, 0,5'd0, 1,5'd4, 1,0, 0,4'b0000,0);

        // MULDIV r6, then a second MULDIV r9: structural stalls
        cyc(0,1,MD ,1,5'd6, 0,5'd0, 0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,MD ,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 1,4'b1000,1);
        cyc(0,1,MD ,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 1,4'b1000,1);
        cyc(0,1,MD ,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 1,4'b1000,1);
        cyc(0,1,MD ,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 0,4'b0000,1);
        // ALU writing r9 behind the MULDIV: waw stalls
        cyc(0,1,ALU,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 1,4'b0100,1);
        cyc(0,1,ALU,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 1,4'b0100,1);
        cyc(0,1,ALU,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 1,4'b0100,1);
        cyc(0,1,ALU,1,5'd9, 0,5'd0, 0,5'd0, 0,0, 0,4'b0000,1);
        // MULDIV r12 reading r9 (cnt 1, no raw), then multi-hot cause
        cyc(0,1,MD ,1,5'd12, 1,5'd9,  0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,MD ,1,5'd12, 1,5'd12, 0,5'd0, 1,0, 1,4'b1011,1);
        // Same instruction flushed: stall drops, nothing issues
        cyc(0,1,MD ,1,5'd12, 1,5'd12, 0,5'd0, 1,1, 0,4'b0000,1);
        idle(1);
        idle(1);
        idle(0);

        // LOAD r7, flushed reader writing r13 leaves no entry
        cyc(0,1,LD ,1,5'd7,  0,5'd0,  0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,ALU,1,5'd13, 1,5'd7,  0,5'd0, 0,1, 0,4'b0000,0);
        cyc(0,1,ALU,0,5'd0,  1,5'd13, 0,5'd0, 1,0, 0,4'b0000,0);
        // r0 write ignored, r0 reads never stall
        cyc(0,1,MD ,1,5'd0,  0,5'd0,  0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,ALU,0,5'd0,  1,5'd0,  1,5'd0, 1,0, 0,4'b0000,1);

        // MULDIV r14 waits out the previous MULDIV, then reset mid-op
        cyc(0,1,MD ,1,5'd14, 0,5'd0, 0,5'd0, 0,0, 1,4'b1000,1);
        cyc(0,1,MD ,1,5'd14, 0,5'd0, 0,5'd0, 0,0, 1,4'b1000,1);
        cyc(0,1,MD ,1,5'd14, 0,5'd0, 0,5'd0, 0,0, 0,4'b0000,1);
        idle(1);
        cyc(1,0,ALU,0,5'd0,  0,5'd0,  0,5'd0, 0,0, 0,4'b0000,1);
        cyc(0,1,ALU,0,5'd0,  1,5'd14, 0,5'd0, 1,0, 0,4'b0000,0);

        // Preload the stall counter near saturation
        @(negedge clk);
        #1;
        force dut.r_stall_cycles = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cycles;
        sc = 32'hFFFF_FFFD;

        // MULDIV r15 then dependent ALU: MD_LAT-1 stalls, counter saturates
        cyc(0,1,MD ,1,5'd15, 0,5'd0,  0,5'd0, 0,0, 0,4'b0000,0);
        cyc(0,1,ALU,1,5'd16, 1,5'd15, 0,5'd0, 0,0, 1,4'b0001,1);
        cyc(0,1,ALU,1,5'd16, 1,5'd15, 0,5'd0, 0,0, 1,4'b0001,1);
        cyc(0,1,ALU,1,5'd16, 1,5'd15, 0,5'd0, 0,0, 1,4'b0001,1);
        cyc(0,1,ALU,1,5'd16, 1,5'd15, 0,5'd0, 0,0, 0,4'b0000,1);
        idle(0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational stall logic.
- A per-register countdown scoreboard tracks in-flight writers of three latency classes: ALU, LOAD and multi-cycle MULDIV.
- Produces a single ID-stage stall that covers:
  - RAW hazards for normal consumers;
  - RAW hazards for ID-resolved branches, which need operands one stage earlier;
  - WAW hazards between writers of unequal latency;
  - a structural hazard on a single non-pipelined MULDIV unit.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- NREG, 32: number of architectural registers; register 0 is hardwired and never tracked.
- AW, $clog2(NREG): register index width.
- LOAD_LAT, 1: extra cycles before a load result can be forwarded to EX.
- MD_LAT, 4: MULDIV occupancy and result latency in cycles; must be >= 1.
- BR_EXTRA, 1: extra cycles a branch resolved in ID needs beyond a normal consumer.
- CW, $clog2(MD_LAT+BR_EXTRA+1): counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  AW  source register A.
- id_rt  in  AW  source register B.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_branch  in  1  compare/jump resolved in ID (uncertain jump).
- id_reg_write  in  1  instruction writes id_rw.
- id_rw  in  AW  destination register.
- id_class  in  2  0=ALU, 1=LOAD, 2=MULDIV, 3=reserved (treated as ALU).
- flush  in  1  the instruction in ID is squashed this cycle.
- stall  out  1  hold PC/IF/ID and bubble EX.
- stall_cause  out  4  {md_struct, waw, br_raw, raw}; may be multi-hot.
- md_busy  out  1  MULDIV unit occupied.
- stall_cycles  out  32  count of stall cycles, saturating.

Behaviour:
- State:
  - cnt[r], CW bits, for r = 1..NREG-1;
  - md_cnt, CW bits;
  - stall_cycles, 32 bits.
- Reset (synchronous) clears all state to 0. Combinational outputs therefore read stall=0, stall_cause=0 and md_busy=0 in the first cycle after reset, whatever the inputs.
- Class latency L: ALU=0, LOAD=LOAD_LAT, MULDIV=MD_LAT-1.
- Issue value: newcnt = L + BR_EXTRA.
- Operand checks apply only to a used, nonzero rs/rt:
  - raw = used operand with cnt > BR_EXTRA;
  - br_raw = id_branch and a used operand with cnt > 0.
- waw = id_reg_write and id_rw != 0 and cnt[id_rw] > newcnt.
- md_struct = id_class == MULDIV and md_cnt > 1.
- stall = id_valid and !flush and (raw | br_raw | waw | md_struct).
- stall_cause bits are valid only while stall is high, and read 0 otherwise.
- issue = id_valid and !flush and !stall.
- Each clock edge:
  - every nonzero cnt decrements by 1;
  - if issue and id_reg_write and id_rw != 0, cnt[id_rw] is loaded with newcnt; the load overrides the decrement.
- MULDIV unit:
  - md_cnt decrements when nonzero;
  - on issue of a MULDIV instruction it is loaded with MD_LAT;
  - md_busy = (md_cnt != 0).
- Self-dependency (rs == rw): the RAW check uses the pre-issue cnt only.
- Writes to r0 are ignored, and reads of r0 never stall.
- stall_cycles increments on every cycle with stall=1 and holds at 0xFFFFFFFF.
- A flush during a stall drops the stall the same cycle; no scoreboard entry is created for the flushed instruction.
- Reset asserted mid-operation discards all pending entries on that edge.
- Resulting default-parameter stall counts:
  - ALU followed by a dependent ALU: 0 stalls.
  - LOAD followed by a dependent ALU: 1 stall.
  - ALU followed by a dependent branch: 1 stall.
  - LOAD followed by a dependent branch: 2 stalls.
  - MULDIV followed by a dependent ALU: MD_LAT-1 stalls.

Test Plan:
- Reset with id_valid=1, id_uses_rs=1, id_rs=5 -> stall=0, md_busy=0, stall_cycles=0.
- Issue LOAD r3, then ALU reading r3 -> exactly 1 stall cycle with stall_cause=0001, then issue; stall_cycles=1.
- Issue LOAD r4, then branch reading r4 -> 2 stall cycles (cause 0011, then 0010), issue in the 3rd cycle. ALU r4 followed by a branch -> 1 stall.
- Issue MULDIV r6, then ALU writing r6 (waw, cause 0100) and a second MULDIV (md_struct) -> stalls until cnt[6] <= 1 and md_cnt <= 1; md_busy is high for 4 cycles after the MULDIV issue.
- Issue LOAD r7; next cycle flush=1 with a dependent reader -> stall=0, no entry for the reader; writes to r0 never set cnt and reads of r0 never stall.
- Force 2^32+5 stall cycles (or preload via a force) -> stall_cycles holds at 0xFFFFFFFF. Assert rst mid-MULDIV -> md_busy=0 and all cnt=0 on the next cycle.
